// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared constants and helpers for the parametrised Fibonacci LFSR.
//   - default WIDTH / TAPS / SEED / STEP for lfsr_gen
//   - primitive tap masks for WIDTH 3..32 in this right-shifting Fibonacci form
//     (bit 0 is always tapped; bit k corresponds to polynomial term x^(WIDTH-k))
//   - lfsr_step1: one sub-step, returning the next state and the shifted-out bit
package lfsr_pkg;

  localparam int          LFSR_DEF_WIDTH = 16;
  localparam logic [15:0] LFSR_DEF_TAPS  = 16'h002D;
  localparam logic [15:0] LFSR_DEF_SEED  = 16'hECEB;
  localparam int          LFSR_DEF_STEP  = 1;
  localparam int          LFSR_MAX_WIDTH = 32;

  // Maximal-length masks, indexed by WIDTH. Entries are right-aligned in 32 bits.
  localparam logic [31:0] LFSR_PRIM_TAPS [3:32] = '{
    32'h0000_0003,  // 3
    32'h0000_0003,  // 4
    32'h0000_0005,  // 5
    32'h0000_0003,  // 6
    32'h0000_0003,  // 7
    32'h0000_001D,  // 8
    32'h0000_0011,  // 9
    32'h0000_0009,  // 10
    32'h0000_0005,  // 11
    32'h0000_0941,  // 12
    32'h0000_1601,  // 13
    32'h0000_2A01,  // 14
    32'h0000_0003,  // 15
    32'h0000_002D,  // 16
    32'h0000_0009,  // 17
    32'h0000_0081,  // 18
    32'h0006_2001,  // 19
    32'h0000_0009,  // 20
    32'h0000_0005,  // 21
    32'h0000_0003,  // 22
    32'h0000_0021,  // 23
    32'h0000_0087,  // 24
    32'h0000_0009,  // 25
    32'h0310_0001,  // 26
    32'h0640_0001,  // 27
    32'h0000_0009,  // 28
    32'h0000_0005,  // 29
    32'h2500_0001,  // 30
    32'h0000_0009,  // 31
    32'hC000_0401   // 32
  };

  typedef struct packed {
    logic [31:0] state;    // next state, right-aligned, bits >= width are zero
    logic        out_bit;  // bit shifted out of position 0
  } lfsr_step_t;

  // Table lookup with a zero result for unsupported widths.
  function automatic logic [31:0] lfsr_prim_taps(input int width);
    logic [31:0] taps;
    taps = 32'h0;
    if (width >= 3 && width <= LFSR_MAX_WIDTH) begin
      taps = LFSR_PRIM_TAPS[width];
    end
    return taps;
  endfunction

  // One Fibonacci sub-step: feedback is the parity of the tapped bits and is
  // shifted in at the MSB while bit 0 falls out.
  function automatic lfsr_step_t lfsr_step1(input logic [31:0] state,
                                            input logic [31:0] taps,
                                            input int          width);
    lfsr_step_t  r;
    logic [31:0] msk;
    logic        fb;
    msk       = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    fb        = ^(state & taps & msk);
    r.out_bit = state[0];
    r.state   = ((state & msk) >> 1) | ({31'd0, fb} << (width - 1));
    return r;
  endfunction

endpackage

// File: rtl/lfsr_step_unroll.sv
// lfsr_step_unroll: purely combinational chain of STEP LFSR sub-steps.
// Ports:
//   state_in  [WIDTH-1:0]  state before the advance
//   state_out [WIDTH-1:0]  state after STEP sub-steps
//   bits_out  [STEP-1:0]   shifted-out bits, bit 0 from the first sub-step
module lfsr_step_unroll
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = LFSR_DEF_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = LFSR_DEF_TAPS,
  parameter int               STEP  = LFSR_DEF_STEP
) (
  input  logic [WIDTH-1:0] state_in,
  output logic [WIDTH-1:0] state_out,
  output logic [STEP-1:0]  bits_out
);

  logic [WIDTH-1:0] chain [0:STEP];

  assign chain[0] = state_in;

  for (genvar i = 0; i < STEP; i++) begin : g_sub
    lfsr_step_t r;

    assign r            = lfsr_step1(32'(chain[i]), 32'(TAPS), WIDTH);
    assign chain[i + 1] = r.state[WIDTH-1:0];
    assign bits_out[i]  = r.out_bit;

    // The helper works on 32-bit containers; the bits above WIDTH are always zero.
    if (WIDTH < 32) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^r.state[31:WIDTH];
    end
  end

  assign state_out = chain[STEP];

endmodule

// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Fibonacci LFSR with seed load and period monitor.
// Ports:
//   clk                     clock
//   rst_n                   asynchronous active-low reset
//   en                      advance the state by STEP sub-steps
//   load                    load load_val as new state and start value (beats en)
//   load_val  [WIDTH-1:0]   value to load; zero is replaced by SEED
//   shift_reg [WIDTH-1:0]   current state
//   rand_bits [STEP-1:0]    bits shifted out by the last advance, bit 0 first
//   wrap                    pulse: last advance returned to the start value
//   period    [WIDTH-1:0]   advances between the two most recent wraps
//   load_err                pulse: a zero load was replaced by SEED
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = LFSR_DEF_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = LFSR_DEF_TAPS,
  parameter logic [WIDTH-1:0] SEED  = LFSR_DEF_SEED,
  parameter int               STEP  = LFSR_DEF_STEP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] shift_reg,
  output logic [STEP-1:0]  rand_bits,
  output logic             wrap,
  output logic [WIDTH-1:0] period,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] start_q;
  logic [WIDTH-1:0] adv_cnt;
  logic [WIDTH-1:0] adv_state;
  logic [STEP-1:0]  adv_bits;
  logic             adv_wraps;
  logic             load_zero;
  logic [WIDTH-1:0] load_state;

  lfsr_step_unroll #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .STEP  (STEP)
  ) u_unroll (
    .state_in  (shift_reg),
    .state_out (adv_state),
    .bits_out  (adv_bits)
  );

  // A zero state would lock up, so it is never allowed in.
  assign load_zero  = (load_val == '0);
  assign load_state = load_zero ? SEED : load_val;

  assign adv_wraps  = (adv_state == start_q);

  // adv_cnt holds the advances since the start value, excluding the current
  // one, so the period reported on a wrap is adv_cnt + 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= SEED;
      start_q   <= SEED;
      rand_bits <= '0;
      wrap      <= 1'b0;
      period    <= '0;
      load_err  <= 1'b0;
      adv_cnt   <= '0;
    end else if (load) begin
      shift_reg <= load_state;
      start_q   <= load_state;
      adv_cnt   <= '0;
      wrap      <= 1'b0;
      load_err  <= load_zero;
    end else if (en) begin
      shift_reg <= adv_state;
      rand_bits <= adv_bits;
      load_err  <= 1'b0;
      if (adv_wraps) begin
        wrap    <= 1'b1;
        period  <= adv_cnt + CNT_ONE;
        adv_cnt <= '0;
      end else begin
        wrap <= 1'b0;
        if (adv_cnt != CNT_MAX) begin
          adv_cnt <= adv_cnt + CNT_ONE;
        end
      end
    end else begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lfsr_gen.sv
module tb_lfsr_gen;

  typedef struct {
    bit [31:0] s;
    bit [31:0] start;
    bit [31:0] per;
    bit [31:0] adv;
    bit [31:0] rb;
    bit [31:0] seed;
    bit [31:0] taps;
    bit [31:0] mask;
    bit        wrap;
    bit        lerr;
    int        w;
    int        step;
  } model_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en, load;
  logic [15:0] load_val;
  logic [15:0] shift_reg, period;
  logic [0:0]  rand_bits;
  logic        wrap, load_err;

  logic        en4, load4;
  logic [3:0]  load_val4;
  logic [3:0]  sr4, rb4, per4;
  logic        wrap4, lerr4;

  int checks = 0;
  int errors = 0;

  model_t m16, m4;

  lfsr_gen u_dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .load      (load),
    .load_val  (load_val),
    .shift_reg (shift_reg),
    .rand_bits (rand_bits),
    .wrap      (wrap),
    .period    (period),
    .load_err  (load_err)
  );

  lfsr_gen #(
    .WIDTH (4),
    .TAPS  (4'b0011),
    .SEED  (4'h1),
    .STEP  (4)
  ) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en4),
    .load      (load4),
    .load_val  (load_val4),
    .shift_reg (sr4),
    .rand_bits (rb4),
    .wrap      (wrap4),
    .period    (per4),
    .load_err  (lerr4)
  );

  // ---------------- reference model ----------------
  function automatic bit [31:0] m_sub(input bit [31:0] s, input int w,
                                      input bit [31:0] taps, output bit ob);
    bit [31:0] fb;
    ob = s[0];
    fb = 32'($countones(s & taps) % 2);
    return (s >> 1) + fb * (32'd1 << (w - 1));
  endfunction

  function automatic model_t m_reset(model_t m);
    m.s = m.seed; m.start = m.seed; m.per = 0; m.adv = 0;
    m.rb = 0; m.wrap = 0; m.lerr = 0;
    return m;
  endfunction

  function automatic model_t m_init(int w, int step, bit [31:0] taps, bit [31:0] seed);
    model_t m;
    m.w = w; m.step = step; m.taps = taps; m.seed = seed;
    m.mask = (32'd1 << w) - 32'd1;
    return m_reset(m);
  endfunction

  function automatic model_t m_adv(model_t m);
    bit ob;
    m.rb = 0;
    for (int i = 0; i < m.step; i++) begin
      m.s = m_sub(m.s, m.w, m.taps, ob);
      m.rb[i] = ob;
    end
    m.lerr = 0;
    if (m.s == m.start) begin
      m.wrap = 1; m.per = (m.adv + 1) & m.mask; m.adv = 0;
    end else begin
      m.wrap = 0;
      if (m.adv != m.mask) m.adv = m.adv + 1;
    end
    return m;
  endfunction

  function automatic model_t m_load(model_t m, bit [31:0] val);
    if (val == 0) begin m.s = m.seed; m.lerr = 1; end
    else begin m.s = val; m.lerr = 0; end
    m.start = m.s; m.adv = 0; m.wrap = 0;
    return m;
  endfunction

  function automatic model_t m_hold(model_t m);
    m.wrap = 0; m.lerr = 0;
    return m;
  endfunction

  function automatic logic [34:0] exp16(model_t m);
    return {m.s[15:0], m.rb[0], m.wrap, m.per[15:0], m.lerr};
  endfunction

  function automatic logic [13:0] exp4(model_t m);
    return {m.s[3:0], m.rb[3:0], m.wrap, m.per[3:0], m.lerr};
  endfunction

  // ---------------- tests ----------------
  task automatic do_reset();
    en = 0; load = 0; load_val = 0; en4 = 0; load4 = 0; load_val4 = 0;
    rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    m16 = m_reset(m16);
    m4  = m_reset(m4);
  endtask

  task automatic test_reset();
    en = 0; load = 0; load_val = 0; en4 = 0; load4 = 0; load_val4 = 0;
    rst_n = 0;
    @(negedge clk);
    checks++;
    if ({shift_reg, rand_bits, wrap, period, load_err} !== {16'hECEB, 1'b0, 1'b0, 16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL reset16 got=%h exp=%h", {shift_reg, rand_bits, wrap, period, load_err},
               {16'hECEB, 1'b0, 1'b0, 16'h0000, 1'b0});
    end
    checks++;
    if ({sr4, rb4, wrap4, per4, lerr4} !== {4'h1, 4'h0, 1'b0, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset4 got=%h exp=%h", {sr4, rb4, wrap4, per4, lerr4},
               {4'h1, 4'h0, 1'b0, 4'h0, 1'b0});
    end
    rst_n = 1;
    @(negedge clk);
    m16 = m_hold(m16);
    checks++;
    if ({shift_reg, rand_bits, wrap, period, load_err} !== exp16(m16)) begin
      errors++;
      $display("FAIL reset_hold got=%h exp=%h", {shift_reg, rand_bits, wrap, period, load_err}, exp16(m16));
    end
  endtask

  task automatic test_single_step();
    do_reset();
    en = 1;
    @(negedge clk);
    en = 0;
    m16 = m_adv(m16);
    checks++;
    if ({shift_reg, rand_bits, wrap, period, load_err} !== exp16(m16)) begin
      errors++;
      $display("FAIL single_step got=%h exp=%h", {shift_reg, rand_bits, wrap, period, load_err}, exp16(m16));
    end
    // ECEB: tapped bits 0,2,3,5 = 1,0,1,1 -> fb=1, new MSB set over ECEB>>1.
    checks++;
    if ({shift_reg, rand_bits} !== {16'hF675, 1'b1}) begin
      errors++;
      $display("FAIL single_step_const got=%h/%b exp=f675/1", shift_reg, rand_bits);
    end
  endtask

  task automatic test_full_period();
    int wraps;
    int wrap_at;
    wraps = 0; wrap_at = 0;
    do_reset();
    for (int k = 1; k <= 65535; k++) begin
      if ($urandom_range(31) == 0) begin
        int gap;
        gap = $urandom_range(3, 1);
        repeat (gap) begin
          en = 0;
          @(negedge clk);
          m16 = m_hold(m16);
          checks++;
          if ({shift_reg, rand_bits, wrap, period, load_err} !== exp16(m16)) begin
            errors++;
            $display("FAIL full_period_idle k=%0d got=%h exp=%h", k,
                     {shift_reg, rand_bits, wrap, period, load_err}, exp16(m16));
          end
        end
      end
      en = 1;
      @(negedge clk);
      m16 = m_adv(m16);
      checks++;
      if ({shift_reg, rand_bits, wrap, period, load_err} !== exp16(m16)) begin
        errors++;
        $display("FAIL full_period_adv k=%0d got=%h exp=%h", k,
                 {shift_reg, rand_bits, wrap, period, load_err}, exp16(m16));
      end
      if (wrap === 1'b1) begin
        wraps++;
        wrap_at = k;
      end
    end
    en = 0;
    checks++;
    if (wraps != 1 || wrap_at != 65535) begin
      errors++;
      $display("FAIL full_period_wrap got count=%0d at=%0d exp count=1 at=65535", wraps, wrap_at);
    end
    checks++;
    if ({period, shift_reg} !== {16'hFFFF, 16'hECEB}) begin
      errors++;
      $display("FAIL full_period_end got per=%h sr=%h exp per=ffff sr=eceb", period, shift_reg);
    end
  endtask

  task automatic test_load_zero();
    load = 1; load_val = 16'h0000; en = 1'($urandom_range(1));
    @(negedge clk);
    load = 0; en = 0;
    m16 = m_load(m16, 32'h0);
    checks++;
    if ({shift_reg, rand_bits, wrap, period, load_err} !== exp16(m16)) begin
      errors++;
      $display("FAIL load_zero got=%h exp=%h", {shift_reg, rand_bits, wrap, period, load_err}, exp16(m16));
    end
    checks++;
    if ({shift_reg, load_err, period} !== {16'hECEB, 1'b1, 16'hFFFF}) begin
      errors++;
      $display("FAIL load_zero_const got sr=%h lerr=%b per=%h exp sr=eceb lerr=1 per=ffff",
               shift_reg, load_err, period);
    end
    @(negedge clk);
    m16 = m_hold(m16);
    checks++;
    if ({shift_reg, rand_bits, wrap, period, load_err} !== exp16(m16) || load_err !== 1'b0) begin
      errors++;
      $display("FAIL load_zero_pulse got=%h exp=%h", {shift_reg, rand_bits, wrap, period, load_err}, exp16(m16));
    end
  endtask

  task automatic test_load_priority();
    load = 1; load_val = 16'h1234; en = 1;
    @(negedge clk);
    load = 0; en = 0;
    m16 = m_load(m16, 32'h1234);
    checks++;
    if ({shift_reg, rand_bits, wrap, period, load_err} !== exp16(m16) || shift_reg !== 16'h1234) begin
      errors++;
      $display("FAIL load_priority got=%h exp=%h", {shift_reg, rand_bits, wrap, period, load_err}, exp16(m16));
    end
    for (int k = 0; k < 300; k++) begin
      int r;
      r = $urandom_range(15);
      load = (r == 0);
      en = (r < 12);
      load_val = ($urandom_range(3) == 0) ? 16'h0000 : 16'($urandom);
      @(negedge clk);
      if (load) m16 = m_load(m16, {16'h0, load_val});
      else if (en) m16 = m_adv(m16);
      else m16 = m_hold(m16);
      checks++;
      if ({shift_reg, rand_bits, wrap, period, load_err} !== exp16(m16)) begin
        errors++;
        $display("FAIL load_random k=%0d got=%h exp=%h", k,
                 {shift_reg, rand_bits, wrap, period, load_err}, exp16(m16));
      end
    end
    load = 0; en = 0;
  endtask

  task automatic test_async_reset();
    en = 1;
    repeat (20) begin
      @(negedge clk);
      m16 = m_adv(m16);
    end
    checks++;
    if ({shift_reg, rand_bits, wrap, period, load_err} !== exp16(m16)) begin
      errors++;
      $display("FAIL async_pre got=%h exp=%h", {shift_reg, rand_bits, wrap, period, load_err}, exp16(m16));
    end
    @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    checks++;
    if ({shift_reg, rand_bits, wrap, period} !== {16'hECEB, 1'b0, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL async_reset got sr=%h rb=%b wrap=%b per=%h exp sr=eceb rb=0 wrap=0 per=0000",
               shift_reg, rand_bits, wrap, period);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    m16 = m_reset(m16);
    m4  = m_reset(m4);
    for (int k = 0; k < 10; k++) begin
      en = (k == 0) ? 1'b1 : 1'($urandom_range(1));
      @(negedge clk);
      m16 = en ? m_adv(m16) : m_hold(m16);
      checks++;
      if ({shift_reg, rand_bits, wrap, period, load_err} !== exp16(m16)) begin
        errors++;
        $display("FAIL async_restart k=%0d got=%h exp=%h", k,
                 {shift_reg, rand_bits, wrap, period, load_err}, exp16(m16));
      end
      if (k == 0) begin
        checks++;
        if (shift_reg !== 16'hF675) begin
          errors++;
          $display("FAIL async_restart_first got=%h exp=f675", shift_reg);
        end
      end
    end
    en = 0;
  endtask

  task automatic test_step4();
    int wraps;
    int wrap_at;
    wraps = 0; wrap_at = 0;
    for (int k = 1; k <= 15; k++) begin
      repeat ($urandom_range(3)) begin
        en4 = 0;
        @(negedge clk);
        m4 = m_hold(m4);
        checks++;
        if ({sr4, rb4, wrap4, per4, lerr4} !== exp4(m4)) begin
          errors++;
          $display("FAIL step4_idle k=%0d got=%h exp=%h", k, {sr4, rb4, wrap4, per4, lerr4}, exp4(m4));
        end
      end
      en4 = 1;
      @(negedge clk);
      m4 = m_adv(m4);
      checks++;
      if ({sr4, rb4, wrap4, per4, lerr4} !== exp4(m4)) begin
        errors++;
        $display("FAIL step4_adv k=%0d got=%h exp=%h", k, {sr4, rb4, wrap4, per4, lerr4}, exp4(m4));
      end
      // 0001 -> out 1,0,0,0 -> state 1001
      if (k == 1) begin
        checks++;
        if ({sr4, rb4} !== {4'h9, 4'b0001}) begin
          errors++;
          $display("FAIL step4_first got sr=%h rb=%b exp sr=9 rb=0001", sr4, rb4);
        end
      end
      if (wrap4 === 1'b1) begin
        wraps++;
        wrap_at = k;
      end
    end
    en4 = 0;
    checks++;
    if (wraps != 1 || wrap_at != 15 || per4 !== 4'hF || sr4 !== 4'h1) begin
      errors++;
      $display("FAIL step4_wrap got count=%0d at=%0d per=%h sr=%h exp count=1 at=15 per=f sr=1",
               wraps, wrap_at, per4, sr4);
    end
  endtask

  task automatic test_back_to_back();
    int wraps;
    int first_at;
    int last_at;
    wraps = 0; first_at = 0; last_at = 0;
    en4 = 1;
    repeat (5) begin
      @(negedge clk);
      m4 = m_adv(m4);
    end
    load4 = 1; load_val4 = 4'h0;
    @(negedge clk);
    load4 = 0;
    m4 = m_load(m4, 32'h0);
    checks++;
    if ({sr4, rb4, wrap4, per4, lerr4} !== exp4(m4) || lerr4 !== 1'b1 || sr4 !== 4'h1) begin
      errors++;
      $display("FAIL b2b_load_zero got=%h exp=%h", {sr4, rb4, wrap4, per4, lerr4}, exp4(m4));
    end
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      m4 = m_adv(m4);
      checks++;
      if ({sr4, rb4, wrap4, per4, lerr4} !== exp4(m4)) begin
        errors++;
        $display("FAIL b2b_adv k=%0d got=%h exp=%h", k, {sr4, rb4, wrap4, per4, lerr4}, exp4(m4));
      end
      if (wrap4 === 1'b1) begin
        wraps++;
        if (first_at == 0) first_at = k;
        last_at = k;
      end
    end
    en4 = 0;
    checks++;
    if (wraps != 2 || first_at != 15 || last_at != 30 || per4 !== 4'hF) begin
      errors++;
      $display("FAIL b2b_wrap got count=%0d first=%0d last=%0d per=%h exp count=2 first=15 last=30 per=f",
               wraps, first_at, last_at, per4);
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m16 = m_init(16, 1, 32'h0000_002D, 32'h0000_ECEB);
    m4  = m_init(4, 4, 32'h0000_0003, 32'h0000_0001);
    test_reset();
    test_single_step();
    test_full_period();
    test_load_zero();
    test_load_priority();
    test_async_reset();
    test_step4();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
